// File: rtl/sync_fifo_pkg.sv
// Shared constants and width helper for the synchronous FWFT FIFO.
package sync_fifo_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 8;

  // Bits needed to index 'value' entries (ceil(log2(value))).
  function automatic int clog2_f(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_ptr.sv
// Wrapping read/write pointer; power-of-two depth makes the wrap a natural rollover.
module sync_fifo_ptr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        inc,
  output logic [clog2_f(DEPTH)-1:0]   ptr
);

  localparam int ADDR_W = clog2_f(DEPTH);

  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W-1:0] ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides and exported fill level.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic [clog2_f(DEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int ADDR_W = clog2_f(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [CNT_W-1:0]  count_d;
  logic [CNT_W-1:0]  count_q;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              push;
  logic              pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  // Full blocks writes even on a same-cycle pop: no pass-through path.
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc   (push),
    .ptr   (wptr)
  );

  sync_fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc   (pop),
    .ptr   (rptr)
  );

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wptr] = wr_data;
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // Storage is deliberately left uncleared by reset; only pointers and count restart.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rptr];

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (WIDTH=4, DEPTH=8).
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rd_data;
  logic [3:0] count;
  logic       full;
  logic       empty;

  int n_checks = 0;
  int n_errors = 0;

  sync_fifo #(.WIDTH(4), .DEPTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] v [23];
    for (int k = 0; k < 23; k++) v[k] = 4'((k * 5 + 1) & 15);

    reset = 1'b1; wr_valid = 1'b1; wr_data = 4'h5; rd_ready = 1'b0;
    step(); step();
    chk("rst_count",    count,    0);
    chk("rst_empty",    empty,    1);
    chk("rst_full",     full,     0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data",  rd_data,  0);
    chk("rst_wr_ready", wr_ready, 1);
    reset = 1'b0; wr_valid = 1'b0;
    step();
    chk("rst_nothing_stored", count, 0);

    // Fill to full with 1..8, try an extra word, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1; wr_data = 4'(i);
      step();
    end
    chk("fill_full",     full,     1);
    chk("fill_wr_ready", wr_ready, 0);
    chk("fill_count",    count,    8);
    wr_data = 4'hF;
    step();
    wr_valid = 1'b0;
    chk("extra_push_count", count, 8);
    for (int i = 1; i <= 8; i++) begin
      chk("drain_valid", rd_valid, 1);
      chk("drain_data",  rd_data,  i);
      rd_ready = 1'b1;
      step();
    end
    rd_ready = 1'b0;
    chk("drain_empty",   empty,   1);
    chk("drain_count",   count,   0);
    chk("drain_rd_data", rd_data, 0);

    // Single push: visible only after the edge.
    wr_valid = 1'b1; wr_data = 4'hA;
    #1;
    chk("single_same_cycle_valid", rd_valid, 0);
    step();
    wr_valid = 1'b0;
    chk("single_valid", rd_valid, 1);
    chk("single_data",  rd_data,  4'hA);
    chk("single_count", count,    1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("single_pop_empty", empty, 1);

    // Preload 3 words, then 20 cycles of simultaneous push and pop.
    for (int k = 0; k < 3; k++) begin
      wr_valid = 1'b1; wr_data = v[k];
      step();
    end
    chk("stream_pre_count", count, 3);
    for (int k = 0; k < 20; k++) begin
      wr_valid = 1'b1; wr_data = v[k + 3]; rd_ready = 1'b1;
      #1;
      chk("stream_data",  rd_data, v[k]);
      chk("stream_count", count,   3);
      step();
    end
    wr_valid = 1'b0;
    chk("stream_post_count", count, 3);
    for (int k = 20; k < 23; k++) begin
      chk("stream_tail", rd_data, v[k]);
      step();
    end
    rd_ready = 1'b0;
    chk("stream_tail_empty", empty, 1);

    // Full with simultaneous push and pop: pop wins, push rejected.
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1; wr_data = 4'(8 + i);
      step();
    end
    chk("full2_full", full, 1);
    wr_valid = 1'b1; wr_data = 4'h1; rd_ready = 1'b1;
    #1;
    chk("full2_head", rd_data, 4'h8);
    step();
    chk("full2_count_after_pop", count, 7);
    chk("full2_not_full",        full,  0);
    rd_ready = 1'b0; wr_data = 4'h2;
    step();
    wr_valid = 1'b0;
    chk("full2_refill_count", count, 8);
    rd_ready = 1'b1;
    for (int i = 9; i <= 15; i++) begin
      chk("full2_drain", rd_data, i);
      step();
    end
    chk("full2_last_is_accepted", rd_data, 4'h2);
    step();
    rd_ready = 1'b0;
    chk("full2_empty", empty, 1);

    // Reset mid-stream with 5 words stored.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 4'(4 + i);
      step();
    end
    wr_valid = 1'b0;
    chk("mid_count", count, 5);
    reset = 1'b1; wr_valid = 1'b1; wr_data = 4'hE; rd_ready = 1'b1;
    step();
    reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    chk("mid_rst_count",   count,   0);
    chk("mid_rst_empty",   empty,   1);
    chk("mid_rst_rd_data", rd_data, 0);
    wr_valid = 1'b1; wr_data = 4'h3;
    step();
    wr_valid = 1'b0;
    chk("post_rst_data",  rd_data, 4'h3);
    chk("post_rst_count", count,   1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
